alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 39 +++
 rtl/alu_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
//==============================================================================
// Module      : alu_sequencer_if
// Description : Request, datapath-control and result signals exchanged
//               between the ALU sequencer and its surroundings.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface alu_sequencer_if;
    logic       start;
    logic       cmd;
    logic [7:0] opa;
    logic [7:0] opb;
    logic [8:0] alu_res;
    logic [7:0] bus_out;
    logic       ai;
    logic       bi;
    logic       op;
    logic       ready;
    logic       done;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       ovf;

    // Requester / datapath side
    modport master (
        output start, cmd, opa, opb, alu_res,
        input  bus_out, ai, bi, op, ready, done, result, carry, zero, ovf
    );

    // Sequencer side
    modport slave (
        input  start, cmd, opa, opb, alu_res,
        output bus_out, ai, bi, op, ready, done, result, carry, zero, ovf
    );
endinterface

`default_nettype wire

// File: rtl/alu_sequencer.sv
//==============================================================================
// Module      : alu_sequencer
// Description : Five-state sequencer that loads operands A and B over a shared
//               bus into an external ALU, captures its result and flags, and
//               pulses done. Optional macro ALU_SEQUENCER_OVF_EN enables the
//               signed-overflow flag; otherwise ovf is tied low.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_sequencer (
    input  wire logic       clk,
    input  wire logic       reset,
    alu_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDA  = 3'd1,
        S_LDB  = 3'd2,
        S_EXEC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_cmd;
    logic [7:0] r_opa;
    logic [7:0] r_opb;
    logic [7:0] r_result;
    logic       r_carry;
    logic       r_zero;

    logic [7:0] w_bus_out;
    logic       w_ai;
    logic       w_bi;
    logic       w_op;
    logic       w_ready;
    logic       w_done;

    // State register plus operand latch (IDLE only) and result capture (EXEC exit)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cmd    <= 1'b0;
            r_opa    <= 8'd0;
            r_opb    <= 8'd0;
            r_result <= 8'd0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && bus.start) begin
                r_cmd <= bus.cmd;
                r_opa <= bus.opa;
                r_opb <= bus.opb;
            end
            if (r_state == S_EXEC) begin
                r_result <= bus.alu_res[7:0];
                r_carry  <= bus.alu_res[8];
                r_zero   <= (bus.alu_res[7:0] == 8'd0);
            end
        end
    end

    // Next-state and Moore outputs decoded from the current state
    always_comb begin
        w_state_nxt = r_state;
        w_bus_out   = 8'd0;
        w_ai        = 1'b0;
        w_bi        = 1'b0;
        w_op        = 1'b0;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.start) begin
                    w_state_nxt = S_LDA;
                end
            end
            S_LDA: begin
                w_bus_out   = r_opa;
                w_ai        = 1'b1;
                w_op        = r_cmd;
                w_state_nxt = S_LDB;
            end
            S_LDB: begin
                w_bus_out   = r_opb;
                w_bi        = 1'b1;
                w_op        = r_cmd;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_op        = r_cmd;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef ALU_SEQUENCER_OVF_EN
    logic r_ovf;
    logic w_ovf;

    // Signed overflow: add overflows when like-signed operands give an
    // opposite-signed result; subtract when unlike-signed operands do.
    always_comb begin
        w_ovf = 1'b0;
        if (r_cmd) begin
            w_ovf = (r_opa[7] != r_opb[7]) && (bus.alu_res[7] != r_opa[7]);
        end else begin
            w_ovf = (r_opa[7] == r_opb[7]) && (bus.alu_res[7] != r_opa[7]);
        end
    end

    // Overflow flag captured alongside the other result flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_ovf <= w_ovf;
        end
    end

    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.bus_out = w_bus_out;
    assign bus.ai      = w_ai;
    assign bus.bi      = w_bi;
    assign bus.op      = w_op;
    assign bus.ready   = w_ready;
    assign bus.done    = w_done;
    assign bus.result  = r_result;
    assign bus.carry   = r_carry;
    assign bus.zero    = r_zero;

endmodule

`default_nettype wire
